// File: rtl/my_sopc_sysid_pkg.sv
// Shared definitions for the system-ID checker.
//   word_t      : one 32-bit Avalon data word
//   state_t     : sequencer states, exposed on the checker's dbg_state port
//   SYSID_ADDR_*: word addresses of the sysid slave registers
//   is_req/is_wait: state classification helpers used for the handshake and timer
package my_sopc_sysid_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_ID  = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_REQ_TS  = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_CHECK   = 3'd5
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Retry counter width; covers MAX_RETRIES up to 7.
  localparam int unsigned RETRY_W = 3;

  function automatic logic is_req(input state_t s);
    return (s == ST_REQ_ID) || (s == ST_REQ_TS);
  endfunction

  function automatic logic is_wait(input state_t s);
    return (s == ST_WAIT_ID) || (s == ST_WAIT_TS);
  endfunction

endpackage

// File: rtl/my_sopc_sysid_timeout.sv
// Read-response timeout counter for the system-ID checker.
// Loaded with TIMEOUT_CYCLES when a read is accepted, then decremented on
// every waiting cycle that has no read data. 'expiring' flags the waiting
// cycle whose decrement would take the count to zero, so a read gets exactly
// TIMEOUT_CYCLES waiting cycles before it is abandoned.
// Ports:
//   clock    in  system clock
//   reset    in  asynchronous, active-high reset
//   load     in  reload the counter (read accepted this cycle)
//   dec      in  waiting cycle without readdatavalid
//   expiring out this decrement exhausts the budget
module my_sopc_sysid_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expiring
);

  localparam logic [CW-1:0] LOAD_VALUE = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VALUE;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expiring = dec && (count == CW'(1));

endmodule

// File: rtl/my_sopc_sysid_checker.sv
// System-ID checker: Avalon-MM read master placed in front of the sysid slave.
// On a start pulse it reads the ID word (address 0) and the timestamp word
// (address 1), compares them with the build-time expectations and reports a
// sticky pass/fail result plus a one-cycle done pulse. A read whose data does
// not arrive within TIMEOUT_CYCLES waiting cycles restarts the whole sequence,
// up to MAX_RETRIES times; a data mismatch is final and never retried.
// Ports:
//   clock, reset         system clock, asynchronous active-high reset
//   start                one-cycle start pulse (ignored while busy or during done)
//   m_address, m_read    read request to the slave (registered)
//   m_waitrequest        slave stall
//   m_readdata           read data
//   m_readdatavalid      read data valid
//   busy                 sequence in progress
//   done                 one-cycle end-of-sequence pulse
//   pass, fail           sticky result, never both set
//   timeout_err          sticky: last failure came from a timeout
//   id_value, ts_value   last captured ID / timestamp words
//   dbg_state            current sequencer state
//
// Handshake: a request is issued by holding m_read=1 with a stable m_address;
// it is accepted on the clock edge where m_read=1 and m_waitrequest=0, after
// which m_read drops. The response is the single cycle with
// m_readdatavalid=1 while waiting for that read; responses at any other time
// are ignored.
module my_sopc_sysid_checker
  import my_sopc_sysid_pkg::*;
#(
  parameter word_t       EXPECTED_ID        = 32'd0,
  parameter word_t       EXPECTED_TIMESTAMP = 32'd1606169382,
  parameter int unsigned TIMEOUT_CYCLES     = 16,
  parameter int unsigned MAX_RETRIES        = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [2:0]  dbg_state
);

  localparam int unsigned        TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  state_t               state;
  logic [RETRY_W-1:0]   retry_cnt;
  logic                 req_accept;
  logic                 timer_dec;
  logic                 timer_expiring;
  logic                 words_match;

  assign req_accept  = is_req(state) && m_read && !m_waitrequest;
  assign timer_dec   = is_wait(state) && !m_readdatavalid;
  assign words_match = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
  assign dbg_state   = state;

  my_sopc_sysid_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CW             (TW)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .load     (req_accept),
    .dec      (timer_dec),
    .expiring (timer_expiring)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      retry_cnt   <= '0;
      m_address   <= SYSID_ADDR_ID;
      m_read      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A start arriving together with the done pulse is dropped.
          if (start && !done) begin
            state       <= ST_REQ_ID;
            busy        <= 1'b1;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout_err <= 1'b0;
            retry_cnt   <= '0;
            m_read      <= 1'b1;
            m_address   <= SYSID_ADDR_ID;
          end
        end

        ST_REQ_ID: begin
          if (req_accept) begin
            state  <= ST_WAIT_ID;
            m_read <= 1'b0;
          end
        end

        ST_WAIT_ID: begin
          if (m_readdatavalid) begin
            id_value  <= m_readdata;
            state     <= ST_REQ_TS;
            m_read    <= 1'b1;
            m_address <= SYSID_ADDR_TS;
          end else if (timer_expiring) begin
            if (retry_cnt < RETRY_LIMIT) begin
              retry_cnt <= retry_cnt + RETRY_W'(1);
              state     <= ST_REQ_ID;
              m_read    <= 1'b1;
              m_address <= SYSID_ADDR_ID;
            end else begin
              fail        <= 1'b1;
              timeout_err <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end

        ST_REQ_TS: begin
          if (req_accept) begin
            state  <= ST_WAIT_TS;
            m_read <= 1'b0;
          end
        end

        ST_WAIT_TS: begin
          if (m_readdatavalid) begin
            ts_value <= m_readdata;
            state    <= ST_CHECK;
          end else if (timer_expiring) begin
            // A timeout on either word restarts from the ID read.
            if (retry_cnt < RETRY_LIMIT) begin
              retry_cnt <= retry_cnt + RETRY_W'(1);
              state     <= ST_REQ_ID;
              m_read    <= 1'b1;
              m_address <= SYSID_ADDR_ID;
            end else begin
              fail        <= 1'b1;
              timeout_err <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end

        ST_CHECK: begin
          pass  <= words_match;
          fail  <= !words_match;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state  <= ST_IDLE;
          m_read <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_sopc_sysid_checker.sv
module tb_my_sopc_sysid_checker;

  localparam logic [31:0] EXP_ID      = 32'd0;
  localparam logic [31:0] EXP_TS      = 32'd1606169382;
  localparam int          TIMEOUT     = 16;
  localparam int          MAX_RETRIES = 2;
  localparam int          NEVER       = -1;
  localparam int          EDGE_LIMIT  = 400;

  logic        clock;
  logic        reset;
  logic        start;
  logic        m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // Scoreboard: per sequence the model pushes latency, pass, fail,
  // timeout_err, id_value, ts_value, reads issued (in that order).
  logic [31:0] exp_q[$];
  logic [31:0] model_id = 32'd0;
  logic [31:0] model_ts = 32'd0;

  // Slave configuration and observation counters
  int          cfg_stall  = 0;
  int          cfg_lat_id = 0;
  int          cfg_lat_ts = 0;
  logic [31:0] cfg_d_id   = 32'd0;
  logic [31:0] cfg_d_ts   = 32'd0;
  bit          spur_mode  = 0;
  int          reads_total = 0;
  int          reads_a0    = 0;
  int          reads_a1    = 0;
  int          hold_err    = 0;
  int          both_err    = 0;
  int          done_cnt    = 0;

  my_sopc_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TIMEOUT),
    .MAX_RETRIES        (MAX_RETRIES)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail            (fail),
    .timeout_err     (timeout_err),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_flags"}, {25'd0, m_read, m_address, busy, done, pass, fail, timeout_err}, 32'd0);
    check_eq({tag, "_id"}, id_value, 32'd0);
    check_eq({tag, "_ts"}, ts_value, 32'd0);
  endtask

  // ---------------- Avalon slave model ----------------
  // Acts #1 after each rising edge. Holds waitrequest for cfg_stall cycles
  // per read, then delivers data lat cycles after the first waiting cycle
  // (NEVER = no response).
  initial begin : slave
    bit          in_req;
    bit          req_addr;
    int          stall_left;
    bit          pend;
    int          pend_lat;
    logic [31:0] pend_data;
    int          lat;
    logic [31:0] data;
    in_req = 0; req_addr = 0; stall_left = 0; pend = 0; pend_lat = 0; pend_data = 0;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = 32'd0;
    forever begin
      @(posedge clock);
      #1;
      m_readdatavalid = 1'b0;
      if (reset) begin
        in_req = 0;
        pend = 0;
        m_waitrequest = 1'b0;
      end else begin
        if (pass && fail) both_err++;
        if (done) done_cnt++;
        if (spur_mode) begin
          m_readdatavalid = 1'b1;
          m_readdata = 32'hDEADBEEF;
        end else if (pend) begin
          if (pend_lat == 0) begin
            m_readdatavalid = 1'b1;
            m_readdata = pend_data;
            pend = 0;
          end else begin
            pend_lat--;
          end
        end
        if (m_read) begin
          if (!in_req) begin
            in_req = 1;
            req_addr = m_address;
            stall_left = cfg_stall;
          end else if (m_address !== req_addr) begin
            hold_err++;
          end
          if (stall_left > 0) begin
            m_waitrequest = 1'b1;
            stall_left--;
          end else begin
            m_waitrequest = 1'b0;
            in_req = 0;
            reads_total++;
            if (req_addr) begin
              reads_a1++; lat = cfg_lat_ts; data = cfg_d_ts;
            end else begin
              reads_a0++; lat = cfg_lat_id; data = cfg_d_id;
            end
            if (lat >= 0) begin
              pend = 1; pend_lat = lat; pend_data = data;
            end
          end
        end else begin
          if (in_req) hold_err++;
          m_waitrequest = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Walks the attempt sequence with plain cycle arithmetic: each read costs
  // 1+stall request cycles, then lat+1 waiting cycles, or TIMEOUT waiting
  // cycles if the response is too late / missing, which restarts the attempt.
  task automatic model_run(input int stall, input int lat_id, input int lat_ts,
                           input logic [31:0] d_id, input logic [31:0] d_ts);
    int cyc   = 0;
    int reads = 0;
    bit ok    = 0;
    bit good;
    for (int a = 0; a <= MAX_RETRIES; a++) begin
      cyc += 1 + stall;
      reads++;
      if (lat_id < 0 || lat_id >= TIMEOUT) begin
        cyc += TIMEOUT;
        continue;
      end
      cyc += lat_id + 1;
      model_id = d_id;
      cyc += 1 + stall;
      reads++;
      if (lat_ts < 0 || lat_ts >= TIMEOUT) begin
        cyc += TIMEOUT;
        continue;
      end
      cyc += lat_ts + 1;
      model_ts = d_ts;
      cyc += 1;
      ok = 1;
      break;
    end
    good = ok && (d_id == EXP_ID) && (d_ts == EXP_TS);
    // Latency counts rising edges from the one sampling start to the one raising done.
    exp_q.push_back(32'(cyc + 1));
    exp_q.push_back({31'd0, good});
    exp_q.push_back({31'd0, !good});
    exp_q.push_back({31'd0, !ok});
    exp_q.push_back(model_id);
    exp_q.push_back(model_ts);
    exp_q.push_back(32'(reads));
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_seq(input int extra_start_at, input bit start_on_done, input string tag);
    int edges = 0;
    bit seen  = 0;
    int r0;
    r0 = reads_total;
    @(posedge clock);
    #1;
    start = 1'b1;
    while (!seen && edges < EDGE_LIMIT) begin
      @(posedge clock);
      #1;
      edges++;
      if (edges == 1) begin
        start = 1'b0;
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
      end
      if (extra_start_at >= 2) begin
        if (edges == extra_start_at) start = 1'b1;
        else if (edges == extra_start_at + 1) start = 1'b0;
      end
      if (done) seen = 1;
    end
    check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check_eq({tag, "_latency"}, 32'(edges), exp_q.pop_front());
    check_eq({tag, "_pass"}, {31'd0, pass}, exp_q.pop_front());
    check_eq({tag, "_fail"}, {31'd0, fail}, exp_q.pop_front());
    check_eq({tag, "_timeout_err"}, {31'd0, timeout_err}, exp_q.pop_front());
    check_eq({tag, "_id_value"}, id_value, exp_q.pop_front());
    check_eq({tag, "_ts_value"}, ts_value, exp_q.pop_front());
    check_eq({tag, "_reads"}, 32'(reads_total - r0), exp_q.pop_front());
    if (start_on_done) start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_seq(input int stall, input int lat_id, input int lat_ts,
                        input logic [31:0] d_id, input logic [31:0] d_ts,
                        input int extra_start_at, input bit start_on_done, input string tag);
    cfg_stall = stall; cfg_lat_id = lat_id; cfg_lat_ts = lat_ts;
    cfg_d_id = d_id; cfg_d_ts = d_ts;
    model_run(stall, lat_id, lat_ts, d_id, d_ts);
    run_seq(extra_start_at, start_on_done, tag);
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5) return r % 4;
    if (r == 6) return TIMEOUT - 1;
    if (r == 7) return TIMEOUT;
    if (r == 8) return NEVER;
    return int'($urandom_range(4, TIMEOUT - 2));
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int          r0;
    int          d0;
    int          h0;
    int          a0;
    logic [31:0] rid;
    logic [31:0] rts;
    start = 1'b0;
    reset = 1'b1;
    #2;
    check_zero("por");
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_zero("reset_state");

    // Nominal: zero-wait slave, response in the first waiting cycle
    do_seq(0, 0, 0, EXP_ID, EXP_TS, 0, 0, "t1_nominal");

    // Wrong ID: mismatch is final, two reads only
    do_seq(0, 0, 0, 32'h1, EXP_TS, 0, 0, "t2_bad_id");

    // Waitrequest stalls: request must stay stable
    h0 = hold_err;
    do_seq(5, 0, 0, EXP_ID, EXP_TS, 0, 0, "t3_stall");
    check_eq("t3_hold_stable", 32'(hold_err - h0), 32'd0);

    // No response at all: three ID attempts then timeout failure
    a0 = reads_a0;
    r0 = reads_a1;
    do_seq(0, NEVER, NEVER, EXP_ID, EXP_TS, 0, 0, "t4_no_valid");
    check_eq("t4_addr0_reads", 32'(reads_a0 - a0), 32'd3);
    check_eq("t4_addr1_reads", 32'(reads_a1 - r0), 32'd0);

    // Timeout boundaries: last allowed waiting cycle vs one past it
    do_seq(1, TIMEOUT - 1, TIMEOUT - 1, EXP_ID, EXP_TS, 0, 0, "edge_last_cycle");
    do_seq(0, 2, TIMEOUT, EXP_ID, EXP_TS, 0, 0, "edge_ts_timeout");
    do_seq(2, 1, 3, EXP_ID, 32'h12345678, 0, 0, "bad_ts");

    // Randomized sequences
    for (int i = 0; i < 16; i++) begin
      int          st;
      int          li;
      int          lt;
      logic [31:0] di;
      logic [31:0] dt;
      st = int'($urandom_range(0, 3));
      li = pick_lat();
      lt = pick_lat();
      di = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
      dt = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
      do_seq(st, li, lt, di, dt, 0, 0, $sformatf("rnd%0d", i));
    end

    // Start while busy: no second sequence
    do_seq(2, 1, 1, EXP_ID, EXP_TS, 3, 0, "busy_start");
    r0 = reads_total;
    repeat (6) @(posedge clock);
    #1;
    check_eq("busy_start_no_reads", 32'(reads_total - r0), 32'd0);
    check_eq("busy_start_idle", {31'd0, busy}, 32'd0);

    // Start coinciding with done: ignored
    do_seq(0, 0, 0, EXP_ID, EXP_TS, 0, 1, "done_start");
    r0 = reads_total;
    repeat (4) @(posedge clock);
    #1;
    check_eq("done_start_no_reads", 32'(reads_total - r0), 32'd0);

    // Spurious readdatavalid while idle
    d0 = done_cnt;
    rid = model_id;
    rts = model_ts;
    spur_mode = 1;
    repeat (6) @(posedge clock);
    #1;
    spur_mode = 0;
    @(posedge clock);
    #1;
    check_eq("spur_id", id_value, rid);
    check_eq("spur_ts", ts_value, rts);
    check_eq("spur_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("spur_idle", {31'd0, busy}, 32'd0);

    // Reset during WAIT_TS
    cfg_stall = 0; cfg_lat_id = 0; cfg_lat_ts = 10;
    cfg_d_id = 32'h1234; cfg_d_ts = EXP_TS;
    pulse_start();
    repeat (4) @(posedge clock);
    #1;
    check_eq("rst_wait_pre_id", id_value, 32'h1234);
    check_eq("rst_wait_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("rst_wait_async");
    @(posedge clock);
    #1;
    check_zero("rst_wait_held");
    #2;
    reset = 1'b0;
    model_id = 32'd0;
    model_ts = 32'd0;
    @(posedge clock);
    #1;
    check_zero("rst_wait_after");
    r0 = reads_total;
    repeat (5) @(posedge clock);
    #1;
    check_eq("rst_wait_no_restart", 32'(reads_total - r0), 32'd0);

    // Reset while a stalled request is on the bus: m_read drops without a clock
    cfg_stall = 8; cfg_lat_id = 0; cfg_lat_ts = 0;
    cfg_d_id = EXP_ID; cfg_d_ts = EXP_TS;
    pulse_start();
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_req_pre_mread", {31'd0, m_read}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_req_mread_async", {31'd0, m_read}, 32'd0);
    check_zero("rst_req_async");
    @(posedge clock);
    #3;
    reset = 1'b0;

    // Recovery after reset
    do_seq(0, 0, 0, EXP_ID, EXP_TS, 0, 0, "post_reset");

    check_eq("never_pass_and_fail", 32'(both_err), 32'd0);
    check_eq("request_hold_global", 32'(hold_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
